// File: rtl/sdram_pkg.sv
// Shared types and width helpers for the SDRAM request arbiter slice.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 13;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_WR = 2'd1,
        ISSUE_RD = 2'd2,
        WAIT_RD  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_DATA_W-1:0] data;
    } wr_entry_t;

    // Pointer carries one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sdram_sync_fifo.sv
// Small show-ahead FIFO; every slot is exposed so the caller can search pending entries.
module sdram_sync_fifo
    import sdram_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        push,
    input  logic [Width-1:0]            push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [Width-1:0]            head,
    output logic [ptr_width(Depth)-1:0] count,
    output logic [Depth-1:0][Width-1:0] entries,
    output logic [Depth-1:0]            entry_valid
);
    localparam int PtrW = ptr_width(Depth);
    localparam int IdxW = PtrW - 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                     (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[IdxW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(do_push);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= push_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < Depth; gi++) begin : g_entry
            // Slot is live when its distance from the read pointer is below the fill count.
            logic [IdxW-1:0] age;
            assign age             = IdxW'(gi) - rd_ptr_q[IdxW-1:0];
            assign entries[gi]     = mem_q[gi];
            assign entry_valid[gi] = ({1'b0, age} < count);
        end
    endgenerate

endmodule

// File: rtl/sdram_req_arbiter.sv
// Buffers user read/write requests and hands them one at a time to the SDRAM controller,
// with read-after-write protection and a bounded write burst while reads wait.
module sdram_req_arbiter
    import sdram_pkg::*;
#(
    parameter int AddrWidth  = SDRAM_ADDR_W,
    parameter int DataWidth  = SDRAM_DATA_W,
    parameter int FifoDepth  = 4,
    parameter int MaxWrBurst = 8
) (
    input  logic                 i_dram_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [AddrWidth-1:0] i_wr_addr,
    input  logic [DataWidth-1:0] i_wr_data,
    input  logic                 i_rd_valid,
    output logic                 o_rd_ready,
    input  logic [AddrWidth-1:0] i_rd_addr,
    output logic                 o_rd_data_valid,
    output logic [DataWidth-1:0] o_rd_data,
    input  logic                 i_ctrl_init_done,
    output logic                 o_ctrl_wr_req,
    output logic                 o_ctrl_rd_req,
    output logic [AddrWidth-1:0] o_ctrl_addr,
    output logic [DataWidth-1:0] o_ctrl_wr_data,
    input  logic                 i_ctrl_ack,
    input  logic                 i_ctrl_rd_valid,
    input  logic [DataWidth-1:0] i_ctrl_rd_data
);
    localparam int WrW  = AddrWidth + DataWidth;
    localparam int PtrW = ptr_width(FifoDepth);
    localparam int CntW = cnt_width(MaxWrBurst);

    logic                            wr_push, wr_pop, wr_full;
    logic [WrW-1:0]                  wr_head;
    logic [PtrW-1:0]                 wr_count;
    logic [FifoDepth-1:0][WrW-1:0]   wr_entries;
    logic [FifoDepth-1:0]            wr_entry_valid;
    logic                            rd_push, rd_pop, rd_full, rd_empty;
    logic [AddrWidth-1:0]            rd_head;
    logic [PtrW-1:0]                 rd_count;
    logic                            unused_wr_empty;
    logic [FifoDepth-1:0][AddrWidth-1:0] unused_rd_entries;
    logic [FifoDepth-1:0]            unused_rd_entry_valid;

    arb_state_t           state_q, state_d;
    logic                 wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] rd_data_q, rd_data_d;
    logic                 rd_data_valid_q, rd_data_valid_d;
    logic [CntW-1:0]      burst_q, burst_d;
    logic                 init_done_q;
    logic                 wr_vis_q, wr_vis_d, rd_vis_q, rd_vis_d;
    logic [FifoDepth-1:0] addr_hit;
    logic                 hazard, rd_ok;

    assign o_wr_ready = !wr_full && !i_rst;
    assign o_rd_ready = !rd_full && !i_rst;
    assign wr_push    = i_wr_valid && o_wr_ready;
    assign rd_push    = i_rd_valid && o_rd_ready;

    sdram_sync_fifo #(.Width(WrW), .Depth(FifoDepth)) u_wr_fifo (
        .clk         (i_dram_clk),
        .srst        (i_rst),
        .push        (wr_push),
        .push_data   ({i_wr_addr, i_wr_data}),
        .pop         (wr_pop),
        .full        (wr_full),
        .empty       (unused_wr_empty),
        .head        (wr_head),
        .count       (wr_count),
        .entries     (wr_entries),
        .entry_valid (wr_entry_valid)
    );

    sdram_sync_fifo #(.Width(AddrWidth), .Depth(FifoDepth)) u_rd_fifo (
        .clk         (i_dram_clk),
        .srst        (i_rst),
        .push        (rd_push),
        .push_data   (i_rd_addr),
        .pop         (rd_pop),
        .full        (rd_full),
        .empty       (rd_empty),
        .head        (rd_head),
        .count       (rd_count),
        .entries     (unused_rd_entries),
        .entry_valid (unused_rd_entry_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < FifoDepth; gi++) begin : g_hazard
            assign addr_hit[gi] = wr_entry_valid[gi] &&
                                  (wr_entries[gi][WrW-1 -: AddrWidth] == rd_head);
        end
    endgenerate

    assign hazard = (|addr_hit) || ((state_q == ISSUE_WR) && (addr_q == rd_head));
    assign rd_ok  = rd_vis_q && !hazard;

    always_comb begin
        state_d         = state_q;
        wr_req_d        = wr_req_q;
        rd_req_d        = rd_req_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rd_data_d       = rd_data_q;
        rd_data_valid_d = 1'b0;
        wr_pop          = 1'b0;
        rd_pop          = 1'b0;
        burst_d         = burst_q;

        case (state_q)
            IDLE: begin
                if (init_done_q) begin
                    if (wr_vis_q && !(rd_ok && (burst_q == CntW'(MaxWrBurst)))) begin
                        state_d  = ISSUE_WR;
                        wr_req_d = 1'b1;
                        addr_d   = wr_head[WrW-1 -: AddrWidth];
                        wdata_d  = wr_head[DataWidth-1:0];
                    end else if (rd_ok) begin
                        state_d  = ISSUE_RD;
                        rd_req_d = 1'b1;
                        addr_d   = rd_head;
                    end
                end
            end
            ISSUE_WR: begin
                if (i_ctrl_ack) begin
                    wr_pop   = 1'b1;
                    wr_req_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            ISSUE_RD: begin
                if (i_ctrl_ack) begin
                    rd_pop   = 1'b1;
                    rd_req_d = 1'b0;
                    state_d  = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (i_ctrl_rd_valid) begin
                    rd_data_d       = i_ctrl_rd_data;
                    rd_data_valid_d = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_empty || rd_pop) begin
            burst_d = '0;
        end else if (wr_pop && (burst_q != CntW'(MaxWrBurst))) begin
            burst_d = burst_q + 1'b1;
        end

        // Arbitration sees pops at once but new pushes one cycle late (two-cycle issue latency).
        wr_vis_d = (wr_count - PtrW'(wr_pop)) != '0;
        rd_vis_d = (rd_count - PtrW'(rd_pop)) != '0;
    end

    always_ff @(posedge i_dram_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            wr_req_q        <= 1'b0;
            rd_req_q        <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
            burst_q         <= '0;
            init_done_q     <= 1'b0;
            wr_vis_q        <= 1'b0;
            rd_vis_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_req_q        <= wr_req_d;
            rd_req_q        <= rd_req_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
            burst_q         <= burst_d;
            init_done_q     <= i_ctrl_init_done;
            wr_vis_q        <= wr_vis_d;
            rd_vis_q        <= rd_vis_d;
        end
    end

    assign o_ctrl_wr_req   = wr_req_q;
    assign o_ctrl_rd_req   = rd_req_q;
    assign o_ctrl_addr     = addr_q;
    assign o_ctrl_wr_data  = wdata_q;
    assign o_rd_data       = rd_data_q;
    assign o_rd_data_valid = rd_data_valid_q;

    // Controller handshake pulses are only meaningful in the states that expect them.
    a_ack_in_issue: assert property (@(posedge i_dram_clk) disable iff (i_rst)
        i_ctrl_ack |-> ((state_q == ISSUE_WR) || (state_q == ISSUE_RD)));
    a_rd_valid_in_wait: assert property (@(posedge i_dram_clk) disable iff (i_rst)
        i_ctrl_rd_valid |-> (state_q == WAIT_RD));

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: a tiny controller model acks each request and returns read data.
module tb_sdram_req_arbiter;

    logic        clk;
    logic        i_rst;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [12:0] i_wr_addr;
    logic [15:0] i_wr_data;
    logic        i_rd_valid;
    logic        o_rd_ready;
    logic [12:0] i_rd_addr;
    logic        o_rd_data_valid;
    logic [15:0] o_rd_data;
    logic        i_ctrl_init_done;
    logic        o_ctrl_wr_req;
    logic        o_ctrl_rd_req;
    logic [12:0] o_ctrl_addr;
    logic [15:0] o_ctrl_wr_data;
    logic        i_ctrl_ack;
    logic        i_ctrl_rd_valid;
    logic [15:0] i_ctrl_rd_data;

    int checks = 0;
    int errors = 0;

    sdram_req_arbiter dut (
        .i_dram_clk       (clk),
        .i_rst            (i_rst),
        .i_wr_valid       (i_wr_valid),
        .o_wr_ready       (o_wr_ready),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data        (i_wr_data),
        .i_rd_valid       (i_rd_valid),
        .o_rd_ready       (o_rd_ready),
        .i_rd_addr        (i_rd_addr),
        .o_rd_data_valid  (o_rd_data_valid),
        .o_rd_data        (o_rd_data),
        .i_ctrl_init_done (i_ctrl_init_done),
        .o_ctrl_wr_req    (o_ctrl_wr_req),
        .o_ctrl_rd_req    (o_ctrl_rd_req),
        .o_ctrl_addr      (o_ctrl_addr),
        .o_ctrl_wr_data   (o_ctrl_wr_data),
        .i_ctrl_ack       (i_ctrl_ack),
        .i_ctrl_rd_valid  (i_ctrl_rd_valid),
        .i_ctrl_rd_data   (i_ctrl_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] wdata_of(input logic [12:0] a);
        return 16'hA000 ^ {3'b000, a};
    endfunction

    task automatic push_wr(input logic [12:0] a);
        int guard = 0;
        i_wr_addr  = a;
        i_wr_data  = wdata_of(a);
        i_wr_valid = 1'b1;
        while (!o_wr_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("wr_accept_bound", guard < 200, 1);
        tick();
        i_wr_valid = 1'b0;
        $display("push wr addr %0h", a);
    endtask

    task automatic push_rd(input logic [12:0] a);
        int guard = 0;
        i_rd_addr  = a;
        i_rd_valid = 1'b1;
        while (!o_rd_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("rd_accept_bound", guard < 200, 1);
        tick();
        i_rd_valid = 1'b0;
        $display("push rd addr %0h", a);
    endtask

    // Controller model: wait for a request, ack it, and for reads return rdata three cycles after the ack.
    task automatic serve_one(input logic [15:0] rdata, output logic got_rd,
                             output logic [12:0] got_addr, output logic [15:0] got_wdata);
        int guard = 0;
        got_rd    = 1'b0;
        got_addr  = '0;
        got_wdata = '0;
        while (!o_ctrl_wr_req && !o_ctrl_rd_req && guard < 60) begin
            tick();
            guard++;
        end
        check("grant_bound", guard < 60, 1);
        if (guard < 60) begin
            got_rd    = o_ctrl_rd_req;
            got_addr  = o_ctrl_addr;
            got_wdata = o_ctrl_wr_data;
            i_ctrl_ack = 1'b1;
            tick();
            i_ctrl_ack = 1'b0;
            check("req_drop", {31'd0, o_ctrl_wr_req | o_ctrl_rd_req}, 0);
            $display("grant %s addr %0h wdata %0h", got_rd ? "rd" : "wr", got_addr, got_wdata);
            if (got_rd) begin
                tick();
                check("wait_rd_quiet1", {31'd0, o_ctrl_wr_req | o_ctrl_rd_req}, 0);
                tick();
                check("wait_rd_quiet2", {31'd0, o_ctrl_wr_req | o_ctrl_rd_req}, 0);
                i_ctrl_rd_data  = rdata;
                i_ctrl_rd_valid = 1'b1;
                tick();
                i_ctrl_rd_valid = 1'b0;
                check("rd_data_valid", o_rd_data_valid, 1);
                check("rd_data", o_rd_data, rdata);
                tick();
                check("rd_valid_pulse", o_rd_data_valid, 0);
            end
        end
    endtask

    task automatic wait_req(input string tag);
        int guard = 0;
        while (!o_ctrl_wr_req && !o_ctrl_rd_req && guard < 60) begin
            tick();
            guard++;
        end
        check(tag, guard < 60, 1);
    endtask

    // Four writes pre-queued, one read, then eight more writes refilled while the controller drains.
    task automatic run_burst(input logic [12:0] base, input logic [12:0] rd_a, input int rd_slot);
        logic        g_rd;
        logic [12:0] g_addr;
        logic [15:0] g_wdata;
        logic [12:0] exp_a;
        i_ctrl_init_done = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) push_wr(base + 13'(i));
        push_rd(rd_a);
        i_ctrl_init_done = 1'b1;
        fork
            begin
                for (int i = 4; i < 12; i++) push_wr(base + 13'(i));
            end
            begin
                for (int k = 0; k < 13; k++) begin
                    serve_one(16'h5A00 + 16'(k), g_rd, g_addr, g_wdata);
                    if (k == rd_slot) begin
                        check("burst_is_rd", g_rd, 1);
                        check("burst_rd_addr", g_addr, rd_a);
                    end else begin
                        exp_a = base + 13'((k < rd_slot) ? k : k - 1);
                        check("burst_is_wr", g_rd, 0);
                        check("burst_wr_addr", g_addr, exp_a);
                        check("burst_wr_data", g_wdata, wdata_of(exp_a));
                    end
                end
            end
        join
    endtask

    initial begin
        logic        g_rd;
        logic [12:0] g_addr;
        logic [15:0] g_wdata;

        i_rst = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_rd_valid = 1'b0;
        i_rd_addr = '0;
        i_ctrl_init_done = 1'b0;
        i_ctrl_ack = 1'b0;
        i_ctrl_rd_valid = 1'b0;
        i_ctrl_rd_data = '0;
        tick();
        tick();
        check("rst_wr_ready", o_wr_ready, 0);
        check("rst_rd_ready", o_rd_ready, 0);
        check("rst_wr_req", o_ctrl_wr_req, 0);
        check("rst_rd_req", o_ctrl_rd_req, 0);
        check("rst_addr", o_ctrl_addr, 0);
        check("rst_rd_valid", o_rd_data_valid, 0);
        i_rst = 1'b0;
        tick();
        check("post_rst_wr_ready", o_wr_ready, 1);
        check("post_rst_rd_ready", o_rd_ready, 1);

        // Init gating
        push_wr(13'h010);
        check("init_wdata_model", wdata_of(13'h010), 16'hBEEF ^ 16'h1EFF);
        tick();
        tick();
        tick();
        check("gate_wr_ready", o_wr_ready, 1);
        check("gate_no_req", o_ctrl_wr_req, 0);
        i_ctrl_init_done = 1'b1;
        tick();
        check("init_lat1_no_req", o_ctrl_wr_req, 0);
        tick();
        check("init_lat2_req", o_ctrl_wr_req, 1);
        check("init_addr", o_ctrl_addr, 13'h010);
        check("init_wdata", o_ctrl_wr_data, wdata_of(13'h010));
        tick();
        tick();
        check("init_hold_req", o_ctrl_wr_req, 1);
        check("init_hold_addr", o_ctrl_addr, 13'h010);
        i_ctrl_ack = 1'b1;
        tick();
        i_ctrl_ack = 1'b0;
        check("init_ack_drop", o_ctrl_wr_req, 0);

        // Fill and backpressure
        i_ctrl_init_done = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push_wr(13'h300 + 13'(i));
        check("full_wr_ready", o_wr_ready, 0);
        i_wr_addr = 13'h3FF;
        i_wr_data = wdata_of(13'h3FF);
        i_wr_valid = 1'b1;
        tick();
        tick();
        i_wr_valid = 1'b0;
        check("full_stays", o_wr_ready, 0);
        i_ctrl_init_done = 1'b1;
        serve_one(16'h0, g_rd, g_addr, g_wdata);
        check("fill_first_addr", g_addr, 13'h300);
        check("ack_frees_ready", o_wr_ready, 1);
        tick();
        check("fill_second_req", o_ctrl_wr_req, 1);
        check("fill_second_addr", o_ctrl_addr, 13'h301);
        i_wr_addr = 13'h304;
        i_wr_data = wdata_of(13'h304);
        i_wr_valid = 1'b1;
        i_ctrl_ack = 1'b1;
        tick();
        i_wr_valid = 1'b0;
        i_ctrl_ack = 1'b0;
        check("push_pop_ready", o_wr_ready, 1);
        push_wr(13'h305);
        check("push_pop_then_full", o_wr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            serve_one(16'h0, g_rd, g_addr, g_wdata);
            check("fill_drain_addr", g_addr, 13'h302 + 13'(i));
        end

        // Read path
        push_rd(13'h020);
        serve_one(16'h1234, g_rd, g_addr, g_wdata);
        check("read_is_rd", g_rd, 1);
        check("read_addr", g_addr, 13'h020);

        // Read starvation bound, then hazard holding the read past the burst limit
        run_burst(13'h200, 13'h100, 8);
        run_burst(13'h400, 13'h409, 10);

        // RAW hazard against an in-flight write
        push_wr(13'h055);
        push_rd(13'h055);
        wait_req("raw_wr_grant");
        check("raw_wr_first", o_ctrl_wr_req, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("raw_no_rd_req", o_ctrl_rd_req, 0);
        end
        i_ctrl_ack = 1'b1;
        tick();
        i_ctrl_ack = 1'b0;
        serve_one(16'hC0DE, g_rd, g_addr, g_wdata);
        check("raw_rd_after", g_rd, 1);
        check("raw_rd_addr", g_addr, 13'h055);

        // Reset while a read is being issued
        push_rd(13'h077);
        wait_req("rst_rd_grant");
        check("rst_in_issue_rd", o_ctrl_rd_req, 1);
        i_rst = 1'b1;
        tick();
        check("mid_rst_rd_req", o_ctrl_rd_req, 0);
        check("mid_rst_wr_req", o_ctrl_wr_req, 0);
        check("mid_rst_addr", o_ctrl_addr, 0);
        check("mid_rst_wdata", o_ctrl_wr_data, 0);
        check("mid_rst_rd_data", o_rd_data, 0);
        check("mid_rst_wr_ready", o_wr_ready, 0);
        check("mid_rst_rd_ready", o_rd_ready, 0);
        i_ctrl_rd_data = 16'hDEAD;
        i_ctrl_rd_valid = 1'b1;
        tick();
        i_ctrl_rd_valid = 1'b0;
        i_rst = 1'b0;
        check("stray_rd_valid", o_rd_data_valid, 0);
        tick();
        check("after_rst_rd_valid", o_rd_data_valid, 0);
        check("after_rst_rd_ready", o_rd_ready, 1);
        check("after_rst_wr_ready", o_wr_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("after_rst_no_req", {31'd0, o_ctrl_wr_req | o_ctrl_rd_req}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
User-side front end that sits directly upstream of the SDRAM controller FSM, in the DRAM clock domain.
- Accepts independent valid/ready write and read request streams and buffers each in a small FIFO.
- Arbitrates them into single level-held requests toward the controller, one at a time.
- Returns read data to the user with a valid strobe.
- Enforces a read-after-write address hazard check and bounds read starvation.

Parameters:
AddrWidth, 13, request address width; matches the controller address bus.
DataWidth, 16, data width; matches the controller data bus.
FifoDepth, 4, entries per request FIFO; must be a power of 2 and at least 2.
MaxWrBurst, 8, maximum consecutive write grants while a read is pending and hazard-free.

Ports:
i_dram_clk  input  1  DRAM clock; the only clock.
i_rst  input  1  reset, synchronous, active-high.
i_wr_valid  input  1  user write request valid.
o_wr_ready  output  1  write FIFO not full.
i_wr_addr  input  AddrWidth  write address.
i_wr_data  input  DataWidth  write data.
i_rd_valid  input  1  user read request valid.
o_rd_ready  output  1  read FIFO not full.
i_rd_addr  input  AddrWidth  read address.
o_rd_data_valid  output  1  one-cycle strobe; o_rd_data is valid.
o_rd_data  output  DataWidth  returned read data.
i_ctrl_init_done  input  1  controller has finished its power-up sequence.
o_ctrl_wr_req  output  1  write request to the controller; held until acknowledged.
o_ctrl_rd_req  output  1  read request to the controller; held until acknowledged.
o_ctrl_addr  output  AddrWidth  request address.
o_ctrl_wr_data  output  DataWidth  write data.
i_ctrl_ack  input  1  one-cycle pulse: controller accepted the current request.
i_ctrl_rd_valid  input  1  one-cycle pulse: i_ctrl_rd_data is valid.
i_ctrl_rd_data  input  DataWidth  read data from the controller.

Behaviour:
- Reset (i_rst high at a clock edge):
  - FIFOs empty; FSM goes to IDLE; write-burst counter is 0.
  - All outputs are 0, including o_wr_ready and o_rd_ready while i_rst is high.
- Ready signals:
  - o_wr_ready = !wr_full and o_rd_ready = !rd_full, both from registered FIFO state.
  - There is no combinational path from any controller input to either ready.
- A push occurs on valid && ready. A push to a full FIFO cannot happen. Push and pop on the same cycle is legal at any fill level, including full.
- FSM states: IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD.
- IDLE:
  - Stays in IDLE while i_ctrl_init_done = 0.
  - Otherwise picks the next request by these rules:
    - Write only pending → ISSUE_WR.
    - Read only pending and hazard-free → ISSUE_RD.
    - Both pending → ISSUE_WR, unless wr_burst_cnt == MaxWrBurst and the read is hazard-free, in which case → ISSUE_RD.
  - On the transition, o_ctrl_addr, o_ctrl_wr_data and the request bit are registered from the FIFO head.
- ISSUE_WR / ISSUE_RD:
  - Request bit and address are held stable until i_ctrl_ack.
  - On i_ctrl_ack: pop the FIFO and drop the request bit on the next edge.
  - ISSUE_WR then → IDLE; ISSUE_RD then → WAIT_RD.
- WAIT_RD:
  - Exactly one read is outstanding.
  - On i_ctrl_rd_valid: o_rd_data is registered from i_ctrl_rd_data, o_rd_data_valid pulses high one cycle later, and the FSM → IDLE.
- Write-burst counter:
  - Increments on each write ack while rd FIFO is non-empty; saturates at MaxWrBurst.
  - Clears on each read ack, and whenever rd FIFO is empty.
- RAW hazard: the read head is blocked while its address equals the address of any valid write FIFO entry, or of a write currently in ISSUE_WR.
- Latency:
  - A write accepted at edge N asserts o_ctrl_wr_req at edge N+2 at the earliest, given idle FSM and init done.
  - One request issues at most every 2 cycles (ack cycle plus IDLE cycle).
- i_ctrl_ack outside ISSUE_*, or i_ctrl_rd_valid outside WAIT_RD, is ignored. An SVA assertion flags both cases.
- i_ctrl_init_done falling mid-operation does not abort the current request; it only blocks new grants from IDLE.
- FIFO pointers are log2(FifoDepth)+1 bits with natural wrap; full/empty are derived from the MSB compare.

Decomposition:
- sdram_pkg holds:
  - arb_state_t enum (IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD);
  - wr_entry_t packed struct {addr, data};
  - the width-derivation localparams.
- Sub-module sdram_sync_fifo (parameterised width/depth; push/pop/full/empty/head).
  - Instantiated twice: write FIFO of wr_entry_t, read FIFO of addresses.
  - Exposes its valid entries for the hazard compare.

Test Plan:
- Init gating: i_ctrl_init_done=0, push write 0x010/0xBEEF → o_wr_ready stays 1, no o_ctrl_wr_req; raise init_done → o_ctrl_wr_req=1 with addr 0x010 and data 0xBEEF two cycles later; held until ack.
- Fill/backpressure: push 4 writes without ack → o_wr_ready=0 after the 4th; 5th valid is not accepted; one ack → o_wr_ready=1 next cycle; push and pop in the same cycle keeps the count at 4.
- Read path: push read 0x020, ack, then i_ctrl_rd_valid with 0x1234 three cycles later → o_rd_data=0x1234, o_rd_data_valid high for exactly one cycle; no new request issued while in WAIT_RD.
- Starvation: 12 queued writes (continuous refill) plus read 0x100 → exactly 8 write grants, then the read grant, then the remaining writes.
- RAW hazard: write 0x055 queued with acks withheld, read 0x055 pushed → no o_ctrl_rd_req until the write ack; read 0x056 instead → granted after the write burst limit.
- Reset mid-operation: assert i_rst while in ISSUE_RD → next cycle all outputs are 0, FIFOs are empty, and a subsequent stray i_ctrl_rd_valid produces no o_rd_data_valid.
